// File: rtl/square_animator_if.sv
// Raster position/enable from the timing generator and the square overlay results back.
// Master drives the raster side; the animator takes the slave modport.
interface square_animator_if #(
    parameter int CORDW = 10
);
    logic [CORDW-1:0] sx;
    logic [CORDW-1:0] sy;
    logic             de;
    logic             pause;
    logic             q_draw;
    logic             de_q;
    logic [CORDW-1:0] qx;
    logic [CORDW-1:0] qy;
    logic             frame;

    modport master (
        output sx, sy, de, pause,
        input  q_draw, de_q, qx, qy, frame
    );

    modport slave (
        input  sx, sy, de, pause,
        output q_draw, de_q, qx, qy, frame
    );
endinterface

// File: rtl/square_animator.sv
// Moving square overlay: steps once per frame on the first blanking line, bounce or wrap (SQUARE_ANIM_WRAP_EN).
// Latency: q_draw/de_q one clk_pix after sx/sy/de; position changes only outside the picture.
// Backpressure: none, consumes one raster position every cycle.
module square_animator #(
    parameter int CORDW  = 10,
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int Q_SIZE = 32,
    parameter int SPEED  = 1,
    parameter int X_INIT = 0,
    parameter int Y_INIT = 0
) (
    input  logic             clk_pix,
    input  logic             rst_n,
    square_animator_if.slave bus
);
    localparam int W = CORDW + 1;
    typedef logic [W-1:0] wide_t;

    localparam wide_t H_W  = wide_t'(H_RES);
    localparam wide_t V_W  = wide_t'(V_RES);
    localparam wide_t Q_W  = wide_t'(Q_SIZE);
    localparam wide_t SP_W = wide_t'(SPEED);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

    state_t           state_q;
    logic [CORDW-1:0] qx_q;
    logic [CORDW-1:0] qy_q;
    logic             dx_q;   // 1 = moving left
    logic             dy_q;   // 1 = moving up
    logic             q_draw_q;
    logic             de_q_q;
    logic             frame_q;

    wide_t sx_w, sy_w, qx_w, qy_w, x_end, y_end;
    logic  upd, move, in_x, in_y;
    logic [CORDW:0] x_d;      // {dir, pos} the axis takes if it moves this strobe
    logic [CORDW:0] y_d;

    assign sx_w  = {1'b0, bus.sx};
    assign sy_w  = {1'b0, bus.sy};
    assign qx_w  = {1'b0, qx_q};
    assign qy_w  = {1'b0, qy_q};
    assign x_end = qx_w + Q_W;
    assign y_end = qy_w + Q_W;

    assign upd  = (bus.sx == '0) && (sy_w == V_W);
    // Once running, every strobe without pause moves, including the one that leaves PAUSED.
    assign move = upd && !bus.pause && (state_q != IDLE);

`ifdef SQUARE_ANIM_WRAP_EN
    function automatic logic [CORDW-1:0] wrap_step(input wide_t pos, input wide_t res);
        wide_t sum;
        sum = pos + SP_W;
        if (sum >= res) begin
            sum = sum - res;
        end
        return sum[CORDW-1:0];
    endfunction

    assign x_d  = {dx_q, wrap_step(qx_w, H_W)};
    assign y_d  = {dy_q, wrap_step(qy_w, V_W)};
    // Square may straddle the right/bottom edge and reappear at 0.
    assign in_x = ((sx_w >= qx_w) && (sx_w < x_end)) || ((x_end > H_W) && (sx_w + H_W < x_end));
    assign in_y = ((sy_w >= qy_w) && (sy_w < y_end)) || ((y_end > V_W) && (sy_w + V_W < y_end));
`else
    function automatic logic [CORDW:0] bounce_step(input wide_t pos, input logic back, input wide_t res);
        wide_t lim;
        wide_t nxt;
        logic  dir;
        lim = res - Q_W;
        dir = back;
        if (!back) begin
            nxt = pos + SP_W;
            if (nxt >= lim) begin
                nxt = lim;
                dir = 1'b1;
            end
        end else if (pos <= SP_W) begin
            nxt = '0;
            dir = 1'b0;
        end else begin
            nxt = pos - SP_W;
        end
        return {dir, nxt[CORDW-1:0]};
    endfunction

    assign x_d  = bounce_step(qx_w, dx_q, H_W);
    assign y_d  = bounce_step(qy_w, dy_q, V_W);
    assign in_x = (sx_w >= qx_w) && (sx_w < x_end);
    assign in_y = (sy_w >= qy_w) && (sy_w < y_end);
`endif

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            qx_q     <= CORDW'(X_INIT);
            qy_q     <= CORDW'(Y_INIT);
            dx_q     <= 1'b0;
            dy_q     <= 1'b0;
            q_draw_q <= 1'b0;
            de_q_q   <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            q_draw_q <= bus.de && in_x && in_y;
            de_q_q   <= bus.de;
            frame_q  <= upd;

            if (upd) begin
                unique case (state_q)
                    IDLE:    state_q <= RUN;
                    RUN:     if (bus.pause) state_q <= PAUSED;
                    PAUSED:  if (!bus.pause) state_q <= RUN;
                    default: state_q <= IDLE;
                endcase
            end

            if (move) begin
                qx_q <= x_d[CORDW-1:0];
                dx_q <= x_d[CORDW];
                qy_q <= y_d[CORDW-1:0];
                dy_q <= y_d[CORDW];
            end
        end
    end

    assign bus.q_draw = q_draw_q;
    assign bus.de_q   = de_q_q;
    assign bus.frame  = frame_q;
    assign bus.qx     = qx_q;
    assign bus.qy     = qy_q;
endmodule

// File: tb/tb_square_animator.sv
// Drives four differently-parameterised animators from one raster source and compares every
// output each cycle with a position/direction model built from the movement rules.
module tb_square_animator;
    localparam int CORDW = 10;
    localparam int ND    = 4;
    localparam int HR [ND] = '{640, 640, 64, 100};
    localparam int VR [ND] = '{480, 480, 64, 80};
    localparam int QS [ND] = '{32, 32, 32, 20};
    localparam int SP [ND] = '{1, 1, 1, 5};
    localparam int XI [ND] = '{0, 607, 31, 3};
    localparam int YI [ND] = '{0, 0, 31, 50};

    logic             clk = 1'b0;
    logic             rst_n;
    logic [CORDW-1:0] sx, sy;
    logic             de, pause;

    logic [ND-1:0]    o_draw, o_deq, o_frame;
    logic [CORDW-1:0] o_qx [ND];
    logic [CORDW-1:0] o_qy [ND];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        square_animator_if #(.CORDW(CORDW)) bus ();
        assign bus.sx     = sx;
        assign bus.sy     = sy;
        assign bus.de     = de;
        assign bus.pause  = pause;
        assign o_draw[g]  = bus.q_draw;
        assign o_deq[g]   = bus.de_q;
        assign o_frame[g] = bus.frame;
        assign o_qx[g]    = bus.qx;
        assign o_qy[g]    = bus.qy;

        square_animator #(
            .CORDW (CORDW),
            .H_RES (HR[g]),
            .V_RES (VR[g]),
            .Q_SIZE(QS[g]),
            .SPEED (SP[g]),
            .X_INIT(XI[g]),
            .Y_INIT(YI[g])
        ) dut (
            .clk_pix(clk),
            .rst_n  (rst_n),
            .bus    (bus)
        );
    end

    // Reference state: has the first strobe been seen, position, direction as +1/-1.
    bit started [ND];
    int mx [ND], my [ND], mdx [ND], mdy [ND];
    int e_draw [ND], e_deq [ND], e_frame [ND];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit covers(int c, int q, int size);
        return (c >= q) && (c < q + size);
    endfunction

    task automatic step_axis(inout int p, inout int dir, input int res, input int size, input int spd);
`ifdef SQUARE_ANIM_WRAP_EN
        p = (p + dir * spd) % res;
`else
        p = p + dir * spd;
        if (dir > 0 && p + size >= res) begin
            p   = res - size;
            dir = -1;
        end else if (dir < 0 && p <= 0) begin
            p   = 0;
            dir = 1;
        end
`endif
    endtask

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            started[d] = 1'b0;
            mx[d] = XI[d];  my[d] = YI[d];
            mdx[d] = 1;     mdy[d] = 1;
            e_draw[d] = 0;  e_deq[d] = 0;  e_frame[d] = 0;
        end
    endtask

    task automatic model_clock();
        for (int d = 0; d < ND; d++) begin
            int x, y;
            bit upd, hx, hy;
            x = int'(sx);
            y = int'(sy);
            upd = (x == 0) && (y == VR[d]);
            hx = covers(x, mx[d], QS[d]);
            hy = covers(y, my[d], QS[d]);
`ifdef SQUARE_ANIM_WRAP_EN
            hx = hx || covers(x + HR[d], mx[d], QS[d]);
            hy = hy || covers(y + VR[d], my[d], QS[d]);
`endif
            e_draw[d]  = int'(de && hx && hy);
            e_deq[d]   = int'(de);
            e_frame[d] = int'(upd);
            if (upd) begin
                if (!started[d]) begin
                    started[d] = 1'b1;
                end else if (!pause) begin
                    step_axis(mx[d], mdx[d], HR[d], QS[d], SP[d]);
                    step_axis(my[d], mdy[d], VR[d], QS[d], SP[d]);
                end
            end
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("dut%0d.q_draw", d), 32'(o_draw[d]),  32'(e_draw[d]));
            chk($sformatf("dut%0d.de_q", d),   32'(o_deq[d]),   32'(e_deq[d]));
            chk($sformatf("dut%0d.frame", d),  32'(o_frame[d]), 32'(e_frame[d]));
            chk($sformatf("dut%0d.qx", d),     32'(o_qx[d]),    32'(mx[d]));
            chk($sformatf("dut%0d.qy", d),     32'(o_qy[d]),    32'(my[d]));
        end
    endtask

    // Inputs are already set; advance one edge and compare at the following falling edge.
    task automatic cycle();
        model_clock();
        @(negedge clk);
        check_all();
    endtask

    task automatic upd_only(input int d);
        sx = '0;
        sy = CORDW'(VR[d]);
        de = 1'b0;
        cycle();
    endtask

    task automatic frame_for(input int d, input logic p_ras, input logic p_upd, output int pulses);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            sx = CORDW'($urandom_range(700, 1));
            sy = CORDW'($urandom_range(520, 0));
            de = 1'($urandom_range(1));
            pause = p_ras;
            cycle();
            pulses += int'(o_frame[d]);
        end
        pause = p_upd;
        upd_only(d);
        pulses += int'(o_frame[d]);
        sx = CORDW'(5);
        cycle();
        pulses += int'(o_frame[d]);
    endtask

    task automatic mid_reset();
        #3 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    int pulses;
    int b_exp [3];
    int t5_x [7] = '{100, 132, 131, 100, 99, 100, 115};
    int t5_y [7] = '{100, 100, 131, 132, 100, 100, 99};
    int t5_de[7] = '{1, 1, 1, 1, 1, 0, 1};
    int t5_q [7] = '{1, 0, 1, 0, 0, 0, 0};

    initial begin
`ifdef SQUARE_ANIM_WRAP_EN
        b_exp = '{607, 608, 609};
`else
        b_exp = '{607, 608, 607};
`endif
        rst_n = 1'b1;
        sx = CORDW'(1);  sy = '0;  de = 1'b0;  pause = 1'b0;
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // First strobe only arms the square; then one step per frame. B bounces at 608.
        for (int f = 0; f < 3; f++) begin
            frame_for(0, 1'b0, 1'b0, pulses);
            chk("t1 frame pulses", 32'(pulses), 32'(1));
            chk("t1 A qx", 32'(o_qx[0]), 32'(f));
            chk("t1 A qy", 32'(o_qy[0]), 32'(f));
            chk("t2 B qx", 32'(o_qx[1]), 32'(b_exp[f]));
        end

        frame_for(0, 1'b1, 1'b1, pulses);
        chk("t4 pause1 qx", 32'(o_qx[0]), 32'(2));
        frame_for(0, 1'b1, 1'b1, pulses);
        chk("t4 pause2 qx", 32'(o_qx[0]), 32'(2));
        frame_for(0, 1'b0, 1'b0, pulses);
        chk("t4 release qx", 32'(o_qx[0]), 32'(3));
        frame_for(0, 1'b1, 1'b0, pulses);
        chk("t4 stray pause qx", 32'(o_qx[0]), 32'(4));

        pause = 1'b0;
        repeat (96) upd_only(0);
        chk("t5 A at 100 qx", 32'(o_qx[0]), 32'(100));
        for (int i = 0; i < 7; i++) begin
            sx = CORDW'(t5_x[i]);
            sy = CORDW'(t5_y[i]);
            de = 1'(t5_de[i]);
            cycle();
            chk($sformatf("t5 draw %0d", i), 32'(o_draw[0]), 32'(t5_q[i]));
        end

        // Small screen C: bounces right at 32, walks back to a corner hit at 0.
        for (int k = 1; k <= 35; k++) begin
            upd_only(2);
            if (k == 2) chk("t3 C bounce qx", 32'(o_qx[2]), 32'(32));
            if (k == 34) begin
                chk("t3 C corner qx", 32'(o_qx[2]), 32'(0));
                chk("t3 C corner qy", 32'(o_qy[2]), 32'(0));
            end
            if (k == 35) begin
                chk("t3 C after qx", 32'(o_qx[2]), 32'(1));
                chk("t3 C after qy", 32'(o_qy[2]), 32'(1));
            end
        end

        sx = CORDW'(300);  sy = CORDW'(200);  de = 1'b1;
        mid_reset();

        for (int n = 0; n < 6000; n++) begin
            int d, x, y;
            d = int'($urandom_range(ND - 1));
            if (n == 3000) mid_reset();
            if ($urandom_range(15) == 0) begin
                sx = '0;
                sy = CORDW'(VR[d]);
                de = 1'b0;
            end else begin
                if ($urandom_range(1) == 1) begin
                    x = mx[d] + int'($urandom_range(QS[d] + 6)) - 3;
                    y = my[d] + int'($urandom_range(QS[d] + 6)) - 3;
                end else begin
                    x = int'($urandom_range(HR[d] + 60));
                    y = int'($urandom_range(VR[d] + 45));
                end
                if (x < 0) x = 0;
                if (y < 0) y = 0;
                sx = CORDW'(x);
                sy = CORDW'(y);
                de = (x < HR[d] && y < VR[d]) ? ($urandom_range(7) != 0) : 1'b0;
            end
            if ($urandom_range(7) == 0) pause = ~pause;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
